// File: rtl/uart_rx_sink_if.sv
// Byte hand-off bus between the UART receiver FIFO and its consumer.
interface uart_rx_sink_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    data_o;   // FIFO head byte, meaningful only while valid_o
  logic          valid_o;  // FIFO not empty
  logic          ready_i;  // consumer accepts the head this cycle
  logic [CW-1:0] count_o;  // bytes currently buffered

  // Receiver side drives the byte stream.
  modport master (
    output data_o,
    output valid_o,
    output count_o,
    input  ready_i
  );

  // Consumer side accepts bytes.
  modport slave (
    input  data_o,
    input  valid_o,
    input  count_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Framing errors and FIFO overruns are reported as one-cycle pulses.
module uart_rx_sink #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             rx_i,
  uart_rx_sink_if.master   sink_if,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;

  logic          rx_meta_q;
  logic          rx_s_q;

  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;

  logic          tick_half;
  logic          tick_full;
  logic          timer_clr;
  logic          shift_en;
  logic          push_set;
  logic          ferr_set;

  logic          push_q;
  logic          frame_err_q;
  logic          overrun_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic          fifo_full;
  logic          fifo_valid;
  logic          pop;
  logic          push_ok;

  assign tick_half = (timer_q == TICK_HALF);
  assign tick_full = (timer_q == TICK_FULL);

  // Two-flop synchronizer for the asynchronous serial line, idle-high.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Receiver next-state logic: start detect, mid-bit sampling, break wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (tick_half) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (tick_full && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (tick_full) state_d = rx_s_q ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver output strobes driving the bit timer, shifter and pulses.
  always_comb begin
    timer_clr = 1'b0;
    shift_en  = 1'b0;
    push_set  = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      S_IDLE:  timer_clr = 1'b1;
      S_START: timer_clr = tick_half;
      S_DATA: begin
        timer_clr = tick_full;
        shift_en  = tick_full;
      end
      S_STOP: begin
        timer_clr = tick_full;
        push_set  = tick_full & rx_s_q;
        ferr_set  = tick_full & ~rx_s_q;
      end
      S_BREAK: timer_clr = 1'b1;
      default: timer_clr = 1'b1;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if (timer_clr) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
      if (state_q != S_DATA) begin
        bit_idx_q <= '0;
      end else if (shift_en) begin
        bit_idx_q <= bit_idx_q + 1'b1;
      end
      if (shift_en) begin
        shift_q <= {rx_s_q, shift_q[7:1]};
      end
    end
  end

  // Stop-sample results are registered; the push lands one cycle later and
  // takes the byte straight from the shifter, which is idle until the next
  // frame's first data bit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= push_set;
      frame_err_q <= ferr_set;
    end
  end

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & sink_if.ready_i;
  assign push_ok    = push_q & (~fifo_full | pop);

  // FIFO occupancy update for every push/pop combination.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers, occupancy and overrun pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q   <= count_d;
      overrun_q <= push_q & fifo_full & ~pop;
    end
  end

  assign sink_if.data_o  = mem_q[rd_ptr_q];
  assign sink_if.valid_o = fifo_valid;
  assign sink_if.count_o = count_q;
  assign frame_err_o     = frame_err_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_uart_rx_sink.sv
// Scenario bench for uart_rx_sink with a queue-based model of the FIFO.
module tb_uart_rx_sink;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  logic rx_i     = 1'b1;
  logic frame_err_o;
  logic overrun_o;

  uart_rx_sink_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_sink #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .rx_i       (rx_i),
    .sink_if    (bus),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_mis = 0;

  int valid_cycles = 0;
  int ferr_cnt     = 0;
  int ovr_cnt      = 0;
  logic [7:0] popped  [$];
  logic [7:0] model_q [$];
  int model_ovr = 0;

  // Observe outputs mid-cycle; a head seen with ready_i high is popped at the next edge.
  always @(negedge clk_i) begin
    if (reset_ni) begin
      if (bus.valid_o) valid_cycles++;
      if (bus.valid_o && bus.ready_i) popped.push_back(bus.data_o);
      if (frame_err_o) ferr_cnt++;
      if (overrun_o) ovr_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_obs();
    valid_cycles = 0;
    ferr_cnt     = 0;
    ovr_cnt      = 0;
    model_ovr    = 0;
    popped.delete();
  endtask

  // Model: a good frame lands if there is room, otherwise it is dropped.
  function automatic void model_frame(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr++;
  endfunction

  // Drive one 8N1 frame; optionally raise ready_i for the final bit cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_end);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      rx_i = fr[k / CPB];
      if (pop_at_end && (k == 10 * CPB - 1)) bus.ready_i = 1'b1;
      step(1);
    end
    if (pop_at_end) bus.ready_i = 1'b0;
  endtask

  task automatic drain(output logic timed_out);
    int i;
    bus.ready_i = 1'b1;
    i = 0;
    while (bus.count_o != '0 && i < 4 * DEPTH) begin
      step(1);
      i++;
    end
    timed_out = (bus.count_o != '0);
    bus.ready_i = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset_ni    = 1'b0;
    bus.ready_i = 1'b0;
    rx_i        = 1'b1;
    step(3);
    n_vec++; if (bus.count_o !== '0) begin n_mis++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    n_vec++; if (bus.valid_o !== 1'b0) begin n_mis++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    n_vec++; if (bus.data_o !== 8'h00) begin n_mis++; $display("FAIL reset_data got=%h exp=00", bus.data_o); end
    n_vec++; if ({frame_err_o, overrun_o} !== 2'b00) begin n_mis++; $display("FAIL reset_pulses got=%b exp=00", {frame_err_o, overrun_o}); end
    reset_ni = 1'b1;
    step(3);
  endtask

  task automatic test_single();
    clear_obs();
    bus.ready_i = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    rx_i = 1'b1;
    step(4);
    bus.ready_i = 1'b0;
    n_vec++; if (valid_cycles != 1) begin n_mis++; $display("FAIL single_valid_cycles got=%0d exp=1", valid_cycles); end
    n_vec++; if (popped.size() != 1) begin n_mis++; $display("FAIL single_pops got=%0d exp=1", popped.size()); end
    else begin
      n_vec++; if (popped[0] !== 8'hA5) begin n_mis++; $display("FAIL single_data got=%h exp=a5", popped[0]); end
    end
    n_vec++; if (ferr_cnt != 0 || ovr_cnt != 0) begin n_mis++; $display("FAIL single_errors got ferr=%0d ovr=%0d exp 0 0", ferr_cnt, ovr_cnt); end
    n_vec++; if (bus.count_o !== '0) begin n_mis++; $display("FAIL single_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_fill_overrun();
    logic [7:0] bytes [4];
    logic [7:0] extra;
    logic to;
    bytes = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    clear_obs();
    model_q.delete();
    bus.ready_i = 1'b0;
    foreach (bytes[i]) begin
      send_frame(bytes[i], 1'b1, 1'b0);
      model_frame(bytes[i]);
    end
    rx_i = 1'b1;
    step(2);
    n_vec++; if (bus.count_o !== 3'(DEPTH)) begin n_mis++; $display("FAIL fill_count got=%0d exp=%0d", bus.count_o, DEPTH); end
    n_vec++; if (bus.valid_o !== 1'b1 || bus.data_o !== model_q[0]) begin n_mis++; $display("FAIL fill_head got v=%b d=%h exp v=1 d=%h", bus.valid_o, bus.data_o, model_q[0]); end
    extra = 8'($urandom);
    send_frame(extra, 1'b1, 1'b0);
    model_frame(extra);
    rx_i = 1'b1;
    step(3);
    n_vec++; if (ovr_cnt != model_ovr) begin n_mis++; $display("FAIL overrun_pulses got=%0d exp=%0d", ovr_cnt, model_ovr); end
    n_vec++; if (bus.count_o !== 3'(DEPTH)) begin n_mis++; $display("FAIL overrun_count got=%0d exp=%0d", bus.count_o, DEPTH); end
    drain(to);
    n_vec++; if (to !== 1'b0) begin n_mis++; $display("FAIL fill_drain_timeout got=%b exp=0", to); end
    n_vec++; if (popped.size() != model_q.size()) begin n_mis++; $display("FAIL fill_pop_len got=%0d exp=%0d", popped.size(), model_q.size()); end
    else begin
      foreach (model_q[i]) begin
        n_vec++; if (popped[i] !== model_q[i]) begin n_mis++; $display("FAIL fill_pop_%0d got=%h exp=%h", i, popped[i], model_q[i]); end
      end
    end
    model_q.delete();
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    clear_obs();
    bus.ready_i = 1'b1;
    rx_i = 1'b0;
    step(3);
    rx_i = 1'b1;
    step(20);
    n_vec++; if (valid_cycles != 0 || ferr_cnt != 0) begin n_mis++; $display("FAIL glitch_quiet got valid=%0d ferr=%0d exp 0 0", valid_cycles, ferr_cnt); end
    n_vec++; if (bus.count_o !== '0) begin n_mis++; $display("FAIL glitch_count got=%0d exp=0", bus.count_o); end
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0);
    rx_i = 1'b1;
    step(4);
    bus.ready_i = 1'b0;
    n_vec++; if (popped.size() != 1 || popped[0] !== b) begin n_mis++; $display("FAIL glitch_recover got n=%0d first=%h exp n=1 first=%h", popped.size(), (popped.size() > 0) ? popped[0] : 8'hxx, b); end
  endtask

  task automatic test_break();
    clear_obs();
    bus.ready_i = 1'b1;
    send_frame(8'h81, 1'b0, 1'b0);
    rx_i = 1'b0;
    step(40);
    rx_i = 1'b1;
    step(4);
    n_vec++; if (ferr_cnt != 1) begin n_mis++; $display("FAIL break_ferr_pulses got=%0d exp=1", ferr_cnt); end
    n_vec++; if (valid_cycles != 0 || bus.count_o !== '0) begin n_mis++; $display("FAIL break_no_push got valid=%0d count=%0d exp 0 0", valid_cycles, bus.count_o); end
    send_frame(8'h81, 1'b1, 1'b0);
    rx_i = 1'b1;
    step(4);
    bus.ready_i = 1'b0;
    n_vec++; if (popped.size() != 1 || popped[0] !== 8'h81) begin n_mis++; $display("FAIL break_recover got n=%0d first=%h exp n=1 first=81", popped.size(), (popped.size() > 0) ? popped[0] : 8'hxx); end
    n_vec++; if (ferr_cnt != 1) begin n_mis++; $display("FAIL break_ferr_after got=%0d exp=1", ferr_cnt); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] b;
    logic [7:0] head;
    logic to;
    clear_obs();
    model_q.delete();
    bus.ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      model_frame(b);
    end
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1);
    head = model_q.pop_front();
    model_q.push_back(b);
    rx_i = 1'b1;
    step(2);
    n_vec++; if (bus.count_o !== 3'(DEPTH) || ovr_cnt != 0) begin n_mis++; $display("FAIL fullpp_count got count=%0d ovr=%0d exp count=%0d ovr=0", bus.count_o, ovr_cnt, DEPTH); end
    n_vec++; if (popped.size() != 1 || popped[0] !== head) begin n_mis++; $display("FAIL fullpp_popped got n=%0d first=%h exp n=1 first=%h", popped.size(), (popped.size() > 0) ? popped[0] : 8'hxx, head); end
    n_vec++; if (bus.data_o !== model_q[0]) begin n_mis++; $display("FAIL fullpp_head got=%h exp=%h", bus.data_o, model_q[0]); end
    popped.delete();
    drain(to);
    n_vec++; if (to !== 1'b0 || popped.size() != model_q.size()) begin n_mis++; $display("FAIL fullpp_drain got to=%b n=%0d exp to=0 n=%0d", to, popped.size(), model_q.size()); end
    else begin
      foreach (model_q[i]) begin
        n_vec++; if (popped[i] !== model_q[i]) begin n_mis++; $display("FAIL fullpp_pop_%0d got=%h exp=%h", i, popped[i], model_q[i]); end
      end
    end
    model_q.delete();
  endtask

  task automatic test_random_batches();
    logic [7:0] b;
    int nfr;
    logic to;
    for (int batch = 0; batch < 3; batch++) begin
      clear_obs();
      model_q.delete();
      bus.ready_i = 1'b0;
      nfr = int'($urandom_range(1, 6));
      for (int f = 0; f < nfr; f++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        model_frame(b);
      end
      rx_i = 1'b1;
      step(3);
      n_vec++; if (ovr_cnt != model_ovr || bus.count_o !== 3'(model_q.size())) begin n_mis++; $display("FAIL rand%0d_state got ovr=%0d count=%0d exp ovr=%0d count=%0d", batch, ovr_cnt, bus.count_o, model_ovr, model_q.size()); end
      drain(to);
      n_vec++; if (to !== 1'b0 || popped.size() != model_q.size()) begin n_mis++; $display("FAIL rand%0d_drain got to=%b n=%0d exp to=0 n=%0d", batch, to, popped.size(), model_q.size()); end
      else begin
        foreach (model_q[i]) begin
          n_vec++; if (popped[i] !== model_q[i]) begin n_mis++; $display("FAIL rand%0d_pop_%0d got=%h exp=%h", batch, i, popped[i], model_q[i]); end
        end
      end
    end
    model_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [9:0] fr;
    clear_obs();
    model_q.delete();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      model_frame(b);
    end
    rx_i = 1'b1;
    step(2);
    n_vec++; if (bus.count_o !== 3'(model_q.size())) begin n_mis++; $display("FAIL rstmid_pre_count got=%0d exp=%0d", bus.count_o, model_q.size()); end
    b  = 8'($urandom);
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 5 * CPB + CPB / 2; k++) begin
      rx_i = fr[k / CPB];
      step(1);
    end
    reset_ni = 1'b0;
    #1;
    model_q.delete();
    n_vec++; if (bus.count_o !== '0 || bus.valid_o !== 1'b0) begin n_mis++; $display("FAIL rstmid_immediate got count=%0d valid=%b exp 0 0", bus.count_o, bus.valid_o); end
    rx_i = 1'b1;
    step(3);
    reset_ni = 1'b1;
    step(4);
    n_vec++; if (bus.count_o !== '0 || bus.data_o !== 8'h00) begin n_mis++; $display("FAIL rstmid_after got count=%0d data=%h exp 0 00", bus.count_o, bus.data_o); end
    bus.ready_i = 1'b1;
    send_frame(8'h42, 1'b1, 1'b0);
    rx_i = 1'b1;
    step(4);
    bus.ready_i = 1'b0;
    n_vec++; if (popped.size() != 1 || popped[0] !== 8'h42) begin n_mis++; $display("FAIL rstmid_recover got n=%0d first=%h exp n=1 first=42", popped.size(), (popped.size() > 0) ? popped[0] : 8'hxx); end
  endtask

  initial begin
    bus.ready_i = 1'b0;
    step(1);
    test_reset();
    test_single();
    test_fill_overrun();
    test_glitch();
    test_break();
    test_full_pop_push();
    test_random_batches();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
